// File: rtl/apb_waitstate_regfile_completer_if.sv
// APB5 bus bundle between a requester and the wait-state register-file completer.
// Clock and reset are kept as plain module ports.
interface apb_waitstate_regfile_completer_if #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned USER_REQ_WIDTH  = 8,
  parameter int unsigned USER_DATA_WIDTH = DATA_WIDTH / 2,
  parameter int unsigned USER_RESP_WIDTH = 16
);
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [ADDR_WIDTH-1:0]      PADDR;
  logic [DATA_WIDTH-1:0]      PWDATA;
  logic [STRB_WIDTH-1:0]      PSTRB;
  logic [2:0]                 PPROT;
  logic                       PWAKEUP;
  logic [USER_REQ_WIDTH-1:0]  PAUSER;
  logic [USER_DATA_WIDTH-1:0] PWUSER;
  logic                       PPARITY;
  logic [DATA_WIDTH-1:0]      PRDATA;
  logic [USER_DATA_WIDTH-1:0] PRUSER;
  logic [USER_RESP_WIDTH-1:0] PBUSER;
  logic                       PREADY;
  logic                       PSLVERR;
  logic                       PPARERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, PWAKEUP, PAUSER, PWUSER, PPARITY,
    input  PRDATA, PRUSER, PBUSER, PREADY, PSLVERR, PPARERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, PWAKEUP, PAUSER, PWUSER, PPARITY,
    output PRDATA, PRUSER, PBUSER, PREADY, PSLVERR, PPARERR
  );
endinterface

// File: rtl/apb_waitstate_regfile_completer.sv
// APB5 completer: byte-strobed register file with programmable wait states and error reporting.
// Optional request parity checking is enabled by defining APB_PARITY_CHECK_EN.
module apb_waitstate_regfile_completer #(
  parameter int unsigned          ADDR_WIDTH      = 32,
  parameter int unsigned          DATA_WIDTH      = 32,
  parameter int unsigned          STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned          USER_REQ_WIDTH  = 8,
  parameter int unsigned          USER_DATA_WIDTH = DATA_WIDTH / 2,
  parameter int unsigned          USER_RESP_WIDTH = 16,
  parameter int unsigned          NUM_REGS        = 16,
  parameter int unsigned          WAIT_STATES     = 2,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE       = 32'hA9B5_0001
) (
  input logic PCLK,
  input logic PRESETn,
  apb_waitstate_regfile_completer_if.slave apb
);

  localparam int unsigned AddrLsb = $clog2(STRB_WIDTH);
  localparam int unsigned IdxW    = $clog2(NUM_REGS);
  localparam int unsigned CntW    = 4;
  localparam int unsigned IdIdx   = NUM_REGS - 1;

  typedef enum logic {StIdle = 1'b0, StAccess = 1'b1} state_e;

  state_e              r_state, w_state_d;
  logic [CntW-1:0]     r_cnt, w_cnt_d;

  logic                       r_write;
  logic [IdxW-1:0]            r_idx;
  logic [STRB_WIDTH-1:0]      r_strb;
  logic [DATA_WIDTH-1:0]      r_wdata;
  logic [USER_DATA_WIDTH-1:0] r_wuser;
  logic [USER_REQ_WIDTH-1:0]  r_auser;
  logic                       r_err;
  logic                       r_par_err;
  logic [DATA_WIDTH-1:0]      r_rdata;
  logic [USER_DATA_WIDTH-1:0] r_ruser;

  logic [DATA_WIDTH-1:0]      r_regs [NUM_REGS];
  logic [USER_DATA_WIDTH-1:0] r_user [NUM_REGS];

  logic                       w_setup;
  logic                       w_complete;
  logic                       w_wr_en;
  logic [IdxW-1:0]            w_idx;
  logic                       w_misaligned;
  logic                       w_out_of_range;
  logic                       w_is_id;
  logic                       w_wr_err;
  logic                       w_par_err;
  logic                       w_err;
  logic [DATA_WIDTH-1:0]      w_rd_data;
  logic [USER_DATA_WIDTH-1:0] w_rd_user;
  logic                       w_unused;

  // A setup phase is honoured in any state, so back-to-back transfers need no idle cycle.
  assign w_setup    = apb.PSEL && !apb.PENABLE;
  assign w_complete = (r_state == StAccess) && apb.PSEL && apb.PENABLE && (r_cnt == '0);
  assign w_wr_en    = w_complete && r_write && !r_err;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    if (w_setup) begin
      w_state_d = StAccess;
      w_cnt_d   = CntW'(WAIT_STATES);
    end else if (r_state == StAccess) begin
      if (!apb.PSEL) begin
        w_state_d = StIdle;
      end else if (apb.PENABLE) begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - 1'b1;
        end else begin
          w_state_d = StIdle;
        end
      end
    end
  end

  // Address decode; range is checked on the full word address so aliases above the file fault.
  assign w_idx = apb.PADDR[AddrLsb +: IdxW];

  if (AddrLsb > 0) begin : g_lsb_check
    assign w_misaligned = |apb.PADDR[AddrLsb-1:0];
  end else begin : g_no_lsb_check
    assign w_misaligned = 1'b0;
  end

  assign w_out_of_range = (apb.PADDR >> AddrLsb) >= ADDR_WIDTH'(NUM_REGS);
  assign w_is_id        = !w_out_of_range && (w_idx == IdxW'(IdIdx));
  assign w_wr_err       = apb.PWRITE &&
                          (w_is_id || ((w_idx == '0) && !apb.PPROT[0]));

`ifdef APB_PARITY_CHECK_EN
  assign w_par_err = apb.PPARITY != (^{apb.PWRITE, apb.PSTRB, apb.PWDATA, apb.PADDR});
`else
  assign w_par_err = 1'b0;
`endif

  assign w_err = w_misaligned || w_out_of_range || w_wr_err || w_par_err;

  always_comb begin
    w_rd_data = '0;
    w_rd_user = '0;
    if (!w_err && !apb.PWRITE) begin
      if (w_is_id) begin
        w_rd_data = ID_VALUE;
      end else begin
        w_rd_data = r_regs[w_idx];
        w_rd_user = r_user[w_idx];
      end
    end
  end

  // Request fields, error verdict and read data are all captured at the setup edge.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_write   <= 1'b0;
      r_idx     <= '0;
      r_strb    <= '0;
      r_wdata   <= '0;
      r_wuser   <= '0;
      r_auser   <= '0;
      r_err     <= 1'b0;
      r_par_err <= 1'b0;
      r_rdata   <= '0;
      r_ruser   <= '0;
    end else if (w_setup) begin
      r_write   <= apb.PWRITE;
      r_idx     <= w_idx;
      r_strb    <= apb.PSTRB;
      r_wdata   <= apb.PWDATA;
      r_wuser   <= apb.PWUSER;
      r_auser   <= apb.PAUSER;
      r_err     <= w_err;
      r_par_err <= w_par_err;
      r_rdata   <= w_rd_data;
      r_ruser   <= w_rd_user;
    end
  end

  // The ID slot is never written because any write to it is flagged as an error.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
        r_user[i] <= '0;
      end
    end else if (w_wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_idx == IdxW'(i)) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (r_strb[b]) begin
              r_regs[i][8*b +: 8] <= r_wdata[8*b +: 8];
            end
          end
          if (|r_strb) begin
            r_user[i] <= r_wuser;
          end
        end
      end
    end
  end

  always_comb begin
    apb.PREADY  = w_complete;
    apb.PSLVERR = 1'b0;
    apb.PRDATA  = '0;
    apb.PRUSER  = '0;
    apb.PBUSER  = '0;
    if (w_complete) begin
      apb.PSLVERR = r_err;
      apb.PRDATA  = r_rdata;
      apb.PRUSER  = r_ruser;
      apb.PBUSER  = USER_RESP_WIDTH'(r_auser);
    end
  end

`ifdef APB_PARITY_CHECK_EN
  assign apb.PPARERR = w_complete && r_par_err;
  assign w_unused    = ^{apb.PWAKEUP, apb.PPROT[2:1]};
`else
  assign apb.PPARERR = 1'b0;
  assign w_unused    = ^{apb.PWAKEUP, apb.PPROT[2:1], apb.PPARITY, r_par_err};
`endif

endmodule
